// File: rtl/ubs_pkg.sv
// Shared types for the pipelined universal barrel shifter.
// UBS_STICKY_EN adds a sticky bit to the per-stage metadata.
package ubs_pkg;

  typedef enum logic [2:0] {
    UBS_LSL = 3'b000,
    UBS_LSR = 3'b001,
    UBS_ROL = 3'b010,
    UBS_ROR = 3'b011,
    UBS_ASL = 3'b100,
    UBS_ASR = 3'b101
  } ubs_mode_e;

  // Width-independent part of the stage payload; data and amount travel beside it
  typedef struct packed {
    logic [2:0] mode;
    logic       carry;
    logic       ovf;
    logic       err;
`ifdef UBS_STICKY_EN
    logic       sticky;
`endif
  } ubs_meta_t;

  function automatic logic ubs_mode_valid(input logic [2:0] mode);
    return (mode != 3'b110) && (mode != 3'b111);
  endfunction

endpackage

// File: rtl/ubs_pipe_if.sv
// Valid/ready bundle for ubs_pipe; master drives operands, slave is the shifter.
// UBS_STICKY_EN adds out_sticky.
interface ubs_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_mode;
  logic [SHW-1:0]   in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic             out_ovf;
  logic             out_err;

`ifdef UBS_STICKY_EN
  logic             out_sticky;

  modport master (
    output in_valid, in_data, in_mode, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_ovf, out_err, out_sticky
  );
  modport slave (
    input  in_valid, in_data, in_mode, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_ovf, out_err, out_sticky
  );
`else
  modport master (
    output in_valid, in_data, in_mode, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_ovf, out_err
  );
  modport slave (
    input  in_valid, in_data, in_mode, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_ovf, out_err
  );
`endif

endinterface

// File: rtl/ubs_stage.sv
// One registered shift-by-2^SHIFT_LOG stage with a valid/ready slice.
// UBS_STICKY_EN accumulates bits discarded by right shifts.
module ubs_stage
  import ubs_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SHW       = 3,
  parameter int unsigned SHIFT_LOG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  input  ubs_meta_t        meta_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   amt_o,
  output ubs_meta_t        meta_o
);

  localparam int unsigned Dist = 1 << SHIFT_LOG;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q, data_s;
  logic [SHW-1:0]   amt_d, amt_q;
  ubs_meta_t        meta_d, meta_q, meta_s;
  logic [Dist:0]    top_bits;
  logic             adv;

  // Bits that must all match the sign for an ASL by Dist to keep the sign
  assign top_bits = data_i[WIDTH-1 -: Dist+1];

  always_comb begin
    data_s = data_i;
    meta_s = meta_i;
    if (amt_i[SHIFT_LOG] && !meta_i.err) begin
      case (meta_i.mode)
        UBS_LSL, UBS_ASL: begin
          data_s       = data_i << Dist;
          meta_s.carry = data_i[WIDTH-Dist];
          if (meta_i.mode == UBS_ASL) begin
            meta_s.ovf = meta_i.ovf | ~((&top_bits) | ~(|top_bits));
          end
        end
        UBS_LSR: begin
          data_s       = data_i >> Dist;
          meta_s.carry = data_i[Dist-1];
`ifdef UBS_STICKY_EN
          meta_s.sticky = meta_i.sticky | (|data_i[Dist-1:0]);
`endif
        end
        UBS_ASR: begin
          data_s       = $signed(data_i) >>> Dist;
          meta_s.carry = data_i[Dist-1];
`ifdef UBS_STICKY_EN
          meta_s.sticky = meta_i.sticky | (|data_i[Dist-1:0]);
`endif
        end
        // Rotate carry is the bit that lands at the far end of the result
        UBS_ROL: begin
          data_s       = (data_i << Dist) | (data_i >> (WIDTH - Dist));
          meta_s.carry = data_i[WIDTH-Dist];
        end
        UBS_ROR: begin
          data_s       = (data_i >> Dist) | (data_i << (WIDTH - Dist));
          meta_s.carry = data_i[Dist-1];
        end
        default: ;
      endcase
    end
  end

  assign adv = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    meta_d  = meta_q;
    if (adv) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_s;
        amt_d  = amt_i;
        meta_d = meta_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      meta_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      meta_q  <= meta_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign meta_o  = meta_q;

endmodule

// File: rtl/ubs_pipe.sv
// Pipelined universal barrel shifter: SHW registered stages, one beat per cycle.
// Define UBS_STICKY_EN to add out_sticky (OR of bits discarded by LSR/ASR).
module ubs_pipe
  import ubs_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SHW   = $clog2(WIDTH),
  localparam int unsigned LAT   = SHW
) (
  input logic       clk,
  input logic       rst,
  ubs_pipe_if.slave bus
);

  logic             valid_w [LAT+1];
  logic [WIDTH-1:0] data_w  [LAT+1];
  logic [SHW-1:0]   amt_w   [LAT+1];
  ubs_meta_t        meta_w  [LAT+1];
  ubs_meta_t        meta_in;
  logic [LAT:0]     ready_w;
  logic             rdy;

  always_comb begin
    meta_in      = '0;
    meta_in.mode = bus.in_mode;
    meta_in.err  = !ubs_mode_valid(bus.in_mode);
  end

  assign valid_w[0] = bus.in_valid;
  assign data_w[0]  = bus.in_data;
  assign amt_w[0]   = bus.in_amt;
  assign meta_w[0]  = meta_in;

  // ready_w[k]: stage k may load this cycle (it is empty or stage k+1 moves on)
  always_comb begin
    rdy          = bus.out_ready;
    ready_w      = '0;
    ready_w[LAT] = rdy;
    for (int k = int'(LAT) - 1; k >= 0; k--) begin
      rdy        = !valid_w[k+1] || rdy;
      ready_w[k] = rdy;
    end
  end

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    ubs_stage #(
      .WIDTH    (WIDTH),
      .SHW      (SHW),
      .SHIFT_LOG(k)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .valid_i(valid_w[k]),
      .data_i (data_w[k]),
      .amt_i  (amt_w[k]),
      .meta_i (meta_w[k]),
      .ready_i(ready_w[k+1]),
      .valid_o(valid_w[k+1]),
      .data_o (data_w[k+1]),
      .amt_o  (amt_w[k+1]),
      .meta_o (meta_w[k+1])
    );
  end

  assign bus.in_ready  = ready_w[0];
  assign bus.out_valid = valid_w[LAT];
  assign bus.out_data  = data_w[LAT];
  // A zero amount never shifts anything out
  assign bus.out_carry = meta_w[LAT].carry & (|amt_w[LAT]);
  assign bus.out_zero  = valid_w[LAT] && (data_w[LAT] == '0);
  assign bus.out_ovf   = meta_w[LAT].ovf;
  assign bus.out_err   = meta_w[LAT].err;
`ifdef UBS_STICKY_EN
  assign bus.out_sticky = meta_w[LAT].sticky;
`endif

endmodule

// File: tb/tb_ubs_pipe.sv
// Self-checking bench for ubs_pipe (WIDTH=8) against a queue-based reference model.
// Sticky checks become active when UBS_STICKY_EN is defined.
module tb_ubs_pipe;

  localparam int unsigned W = 8;
`ifdef UBS_STICKY_EN
  localparam bit HasStk = 1'b1;
`else
  localparam bit HasStk = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ubs_pipe_if #(.WIDTH(W)) bus ();
  ubs_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [12:0] exp_q[$];
  logic        held     = 1'b0;
  logic [13:0] held_vec;
  bit          rnd_done = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, got, exp);
  endtask

  // {sticky, data[7:0], carry, zero, ovf, err}
  function automatic logic [12:0] model(input logic [7:0] x, input logic [2:0] m,
                                        input logic [2:0] a);
    int ai;
    logic [7:0] d;
    logic c, o, e, s;
    ai = int'(a);
    d = x; c = 1'b0; o = 1'b0; e = 1'b0; s = 1'b0;
    case (m)
      3'd0, 3'd4: begin d = x << ai; if (ai != 0) c = x[8-ai]; end
      3'd1: begin
        d = x >> ai;
        if (ai != 0) begin c = x[ai-1]; s = |(x & 8'((1 << ai) - 1)); end
      end
      3'd2: begin d = (x << ai) | (x >> (8 - ai)); if (ai != 0) c = d[0]; end
      3'd3: begin d = (x >> ai) | (x << (8 - ai)); if (ai != 0) c = d[7]; end
      3'd5: begin
        d = 8'($signed(x) >>> ai);
        if (ai != 0) begin c = x[ai-1]; s = |(x & 8'((1 << ai) - 1)); end
      end
      default: e = 1'b1;
    endcase
    if (m == 3'd4) for (int i = 7 - ai; i <= 7; i++) if (x[i] != x[7]) o = 1'b1;
    if (!HasStk) s = 1'b0;
    return {s, d, c, (d == 8'h00), o, e};
  endfunction

  function automatic logic [12:0] dut_vec();
    logic s;
`ifdef UBS_STICKY_EN
    s = bus.out_sticky;
`else
    s = 1'b0;
`endif
    return {s, bus.out_data, bus.out_carry, bus.out_zero, bus.out_ovf, bus.out_err};
  endfunction

  // Scoreboard: every cycle with out_valid is compared against the oldest accepted beat
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) check("hold_stable", {bus.out_valid, dut_vec()}, held_vec);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
        else begin
          check("out", dut_vec(), exp_q[0]);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      held     = bus.out_valid && !bus.out_ready;
      held_vec = {bus.out_valid, dut_vec()};
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_data, bus.in_mode, bus.in_amt));
    end
  end

  task automatic put(input logic [7:0] x, input logic [2:0] m, input logic [2:0] a);
    logic ok;
    int   guard;
    guard = 0;
    bus.in_valid = 1'b1; bus.in_data = x; bus.in_mode = m; bus.in_amt = a;
    do begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1; guard++;
    end while (!ok && guard < 200);
    if (!ok) check("put_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // One isolated beat: result must appear exactly 3 cycles after acceptance
  task automatic run_one(input string name, input logic [7:0] x, input logic [2:0] m,
                         input logic [2:0] a, input logic [11:0] exp, input logic exp_s);
    logic [12:0] v;
    bus.in_valid = 1'b1; bus.in_data = x; bus.in_mode = m; bus.in_amt = a;
    @(negedge clk); check({name, "_acc"}, bus.in_ready, 1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); check({name, "_early"}, bus.out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk); v = dut_vec();
    check(name, {bus.out_valid, v}, {1'b1, exp_s, exp});
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] rnd_data();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    n_checks++;
    finish_run();
  end

  initial begin
    logic [12:0] pv;
    logic [11:0] seen;
    logic        ok;
    int          n_stall;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = '0; bus.in_amt = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outs", {bus.out_valid, dut_vec()}, 0);
    check("reset_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Hand-derived values pin the model itself
    pv = model(8'h96, 3'd0, 3'd1); check("pin_lsl", pv[11:0], {8'h2C, 4'b1000});
    pv = model(8'h96, 3'd5, 3'd3); check("pin_asr", pv[11:0], {8'hF2, 4'b1000});
    pv = model(8'h96, 3'd3, 3'd4); check("pin_ror", pv[11:0], {8'h69, 4'b0000});
    pv = model(8'h40, 3'd4, 3'd1); check("pin_asl", pv[11:0], {8'h80, 4'b0010});
    pv = model(8'h5A, 3'd7, 3'd2); check("pin_rsv", pv[11:0], {8'h5A, 4'b0001});
    pv = model(8'h80, 3'd5, 3'd7); check("pin_asr_max", pv[11:0], {8'hFF, 4'b0000});

    run_one("lsl_96_1", 8'h96, 3'd0, 3'd1, {8'h2C, 4'b1000}, 1'b0);
    run_one("asr_96_3", 8'h96, 3'd5, 3'd3, {8'hF2, 4'b1000}, HasStk);
    run_one("ror_96_4", 8'h96, 3'd3, 3'd4, {8'h69, 4'b0000}, 1'b0);
    run_one("asl_40_1", 8'h40, 3'd4, 3'd1, {8'h80, 4'b0010}, 1'b0);
    run_one("lsr_96_3", 8'h96, 3'd1, 3'd3, {8'h12, 4'b1000}, HasStk);
    run_one("lsr_90_3", 8'h90, 3'd1, 3'd3, {8'h12, 4'b0000}, 1'b0);
    run_one("asr_80_7", 8'h80, 3'd5, 3'd7, {8'hFF, 4'b0000}, 1'b0);
    run_one("lsl_80_1", 8'h80, 3'd0, 3'd1, {8'h00, 4'b1100}, 1'b0);
    run_one("rol_96_0", 8'h96, 3'd2, 3'd0, {8'h96, 4'b0000}, 1'b0);
    run_one("rol_96_3", 8'h96, 3'd2, 3'd3, {8'hB4, 4'b0000}, 1'b0);
    run_one("rsv_5a",   8'h5A, 3'd7, 3'd3, {8'h5A, 4'b0001}, 1'b0);

    // Back-to-back: 8 beats, results in 8 consecutive cycles starting 3 cycles later
    fork
      for (int i = 0; i < 8; i++) put(rnd_data(), 3'($urandom_range(0, 5)), 3'($urandom));
      for (int i = 0; i < 12; i++) begin @(negedge clk); seen[i] = bus.out_valid; end
    join
    check("b2b_timing", seen, 12'h7F8);
    @(posedge clk); #1;

    // Stall: downstream blocked for 6 cycles while beats are offered
    bus.out_ready = 1'b0;
    n_stall = 0;
    bus.in_valid = 1'b1; bus.in_data = rnd_data(); bus.in_mode = 3'($urandom); bus.in_amt = 3'($urandom);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); ok = bus.in_ready;
      if (ok) n_stall++;
      @(posedge clk); #1;
      if (ok) begin
        bus.in_data = rnd_data(); bus.in_mode = 3'($urandom); bus.in_amt = 3'($urandom);
      end
    end
    check("stall_accepted", n_stall, 3);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("stall_in_ready", bus.in_ready, 0);
    check("stall_out_valid", bus.out_valid, 1);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("stall_drained", exp_q.size(), 0);

    // Reset with two beats in flight
    put(8'h33, 3'd0, 3'd2);
    put(8'hC4, 3'd5, 3'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_data", bus.out_data, 0);
    check("rst_mid_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); check("rst_no_ghost", bus.out_valid, 0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          put(rnd_data(), 3'($urandom_range(0, 7)), 3'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1 check("final_drain", exp_q.size(), 0);
    finish_run();
  end

endmodule
